// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if: operand/result handshake bundle for pipe_addsub; master = producer/consumer side, slave = pipeline side
interface pipe_addsub_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero, busy;
  logic [WIDTH-1:0] a, b, sum;
  modport master(output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf, zero, busy);
  modport slave(input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf, zero, busy);
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep chunked add/sub pipeline; ports clk, rst_n (sync active-low), bus slave (in: in_valid a b cin sub out_ready; out: in_ready out_valid sum cout ovf zero busy); define PIPE_ADDSUB_SAT_EN for signed saturation
module pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst_n,
  pipe_addsub_if.slave bus
);
  localparam int CW = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;
  logic [STAGES-1:0] v, iv, c_r, xc, nc;
  logic [WIDTH-1:0] a_r[STAGES], b_r[STAGES], s_r[STAGES];
  logic [WIDTH-1:0] xa[STAGES], xb[STAGES], xs[STAGES], ns[STAGES];
  logic [CW:0] t[STAGES];
  logic [WIDTH-1:0] res;
  logic stall, ovf_n, ovf_r, zero_r;
  always_comb begin
    xa[0] = bus.a;
    xb[0] = bus.b ^ {WIDTH{bus.sub}};
    xs[0] = '0;
    xc[0] = bus.cin ^ bus.sub;
    iv[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      xa[k] = a_r[k-1];
      xb[k] = b_r[k-1];
      xs[k] = s_r[k-1];
      xc[k] = c_r[k-1];
      iv[k] = v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      t[k] = {1'b0, xa[k][k*CW +: CW]} + {1'b0, xb[k][k*CW +: CW]} + (CW+1)'(xc[k]);
      ns[k] = xs[k];
      ns[k][k*CW +: CW] = t[k][CW-1:0];
      nc[k] = t[k][CW];
    end
  end
  assign ovf_n = (xa[STAGES-1][MSB] == xb[STAGES-1][MSB]) && (ns[STAGES-1][MSB] != xa[STAGES-1][MSB]);
`ifdef PIPE_ADDSUB_SAT_EN
  assign res = ovf_n ? {xa[STAGES-1][MSB], {MSB{~xa[STAGES-1][MSB]}}} : ns[STAGES-1];
`else
  assign res = ns[STAGES-1];
`endif
  assign stall = v[STAGES-1] && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign bus.out_valid = v[STAGES-1];
  assign bus.busy = |v;
  assign bus.sum = s_r[STAGES-1];
  assign bus.cout = c_r[STAGES-1];
  assign bus.ovf = ovf_r;
  assign bus.zero = zero_r;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      c_r <= '0;
      ovf_r <= 1'b0;
      zero_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else if (!stall) begin
      v <= iv;
      c_r <= nc;
      ovf_r <= ovf_n;
      zero_r <= res == '0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= xa[k];
        b_r[k] <= xb[k];
        s_r[k] <= k == STAGES - 1 ? res : ns[k];
      end
    end
  end
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed self-checking bench for pipe_addsub (WIDTH 32, STAGES 4)
module tb_pipe_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  typedef struct {
    logic [31:0] a, b;
    logic cin, sub;
    logic [31:0] s_wrap, s_sat;
    logic cout, ovf, zero;
  } vec_t;
  vec_t vecs[6];
  pipe_addsub_if #(.WIDTH(32)) bus();
  pipe_addsub #(.WIDTH(32), .STAGES(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input int i, input vec_t v);
    int lat;
    logic [31:0] s;
`ifdef PIPE_ADDSUB_SAT_EN
    s = v.s_sat;
`else
    s = v.s_wrap;
`endif
    bus.a = v.a;
    bus.b = v.b;
    bus.cin = v.cin;
    bus.sub = v.sub;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      tick;
      lat++;
    end
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
    chk($sformatf("v%0d_sum", i), bus.sum, s);
    chk($sformatf("v%0d_cout", i), 32'(bus.cout), 32'(v.cout));
    chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(v.ovf));
    chk($sformatf("v%0d_zero", i), 32'(bus.zero), 32'(v.zero));
    tick;
  endtask
  initial begin
    logic [31:0] exp_q[8];
    logic [31:0] hold_s;
    int tx, rx, stall_left, stale;
    bit started, released, held;
    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0100_0001, 32'h0100_0001, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    tick;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sum", bus.sum, 32'd0);
    chk("rst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    for (int i = 0; i < 8; i++) exp_q[i] = 32'(i) * 32'h1111_1111 + 32'h0000_FFFF;
    tx = 0;
    rx = 0;
    stall_left = 0;
    started = 0;
    released = 0;
    held = 0;
    hold_s = '0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      if (bus.out_valid && !started) begin
        started = 1;
        stall_left = 5;
      end
      bus.out_ready = stall_left == 0;
      if (stall_left > 0) stall_left--;
      bus.in_valid = tx < 8;
      bus.a = 32'(tx) * 32'h1111_1111;
      bus.b = 32'h0000_FFFF;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (held) chk("stall_sum_stable", bus.sum, hold_s);
        hold_s = bus.sum;
        held = 1;
      end
      if (released && rx < 8) chk("burst_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("order%0d", rx), bus.sum, exp_q[rx]);
        rx++;
        released = started;
      end
      if (bus.in_valid && bus.in_ready) tx++;
      tick;
    end
    chk("burst_count", 32'(rx), 32'd8);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 32'(i + 1);
      bus.b = 32'h0000_0001;
      tick;
    end
    bus.in_valid = 1'b0;
    chk("inflight_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_sum", bus.sum, 32'd0);
    chk("mid_rst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.out_valid || bus.busy) stale++;
    end
    chk("no_stale", 32'(stale), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 8..64.
REQ-002 Parameter: STAGES, default 4, number of pipeline stages; legal values 1..8; WIDTH SHALL be divisible by STAGES, and each stage SHALL add one chunk of CW = WIDTH/STAGES bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 cin  input  1  carry-in.
REQ-009 sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of the MSB.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  sum equals 0.
REQ-016 busy  output  1  at least one pipeline stage holds a valid item.

Function
REQ-017 Effective operands SHALL be b' = b XOR {WIDTH{sub}} and c0 = cin XOR sub, so that add gives a+b+cin and subtract gives a-b-cin.
REQ-018 Stage k (1..STAGES) SHALL ripple-add chunk k-1 (bits k*CW-1 : (k-1)*CW) using the carry registered by stage k-1; stage 1 SHALL use c0.
REQ-019 Unprocessed operand chunks and completed sum chunks SHALL travel with each item; there SHALL be no combinational carry path between stages.
REQ-020 Stall = out_valid AND NOT out_ready; when stall = 1, no stage register SHALL change.
REQ-021 in_ready SHALL equal NOT stall; an item is accepted on an edge where in_valid AND in_ready = 1.
REQ-022 Latency SHALL be STAGES edges: an item accepted at edge k, with no stall, SHALL be presented on the out_* ports after edge k+STAGES-1.
REQ-023 Throughput SHALL be one item per cycle when no stall; bubbles (in_valid = 0) SHALL propagate as invalid stages.
REQ-024 Order SHALL be preserved; under any pattern of out_ready, no item SHALL be lost or duplicated.
REQ-025 While out_valid = 1 and out_ready = 0, sum, cout, ovf and zero SHALL hold stable.
REQ-026 ovf SHALL be (a[MSB] == b'[MSB]) AND (sum[MSB] != a[MSB]), using the unsaturated sum.
REQ-027 cout SHALL be the raw carry out of the MSB; in subtract mode cout = 1 means no borrow.
REQ-028 zero SHALL be computed on the final, post-configuration sum value.
REQ-029 busy SHALL be the OR of all stage valid bits.

Reset
REQ-030 When rst_n = 0 at an edge, all stage valid bits SHALL clear, and out_valid, busy, sum, cout, ovf and zero SHALL all be 0 after that edge.
REQ-031 Items in flight when reset is asserted SHALL be discarded; none SHALL emerge after reset.
REQ-032 in_ready SHALL be 1 during and after reset, because out_valid = 0.

Configuration
REQ-033 Macro PIPE_ADDSUB_SAT_EN defined: when ovf = 1, sum SHALL saturate to 0x7F..F if a[MSB] = 0, otherwise to 0x80..0; cout and ovf SHALL be unchanged.
REQ-034 Macro PIPE_ADDSUB_SAT_EN undefined: sum SHALL wrap modulo 2^WIDTH, and no saturation logic SHALL be present.

Verification (WIDTH = 32, STAGES = 4, out_ready = 1 unless stated)
REQ-035 a = 0x0000_0001, b = 0xFFFF_FFFF, add, cin = 0 -> after 4 edges: sum = 0, cout = 1, zero = 1, ovf = 0.
REQ-036 a = 0x00FF_FFFF, b = 0x0000_0001, add, cin = 1 -> sum = 0x0100_0001, cout = 0; checks carry across chunk boundaries.
REQ-037 a = 0x7FFF_FFFF, b = 1, add -> ovf = 1; sum = 0x8000_0000 without the macro, 0x7FFF_FFFF with PIPE_ADDSUB_SAT_EN.
REQ-038 a = 0x8000_0000, b = 1, sub, cin = 0 -> ovf = 1, cout = 1; sum = 0x7FFF_FFFF without the macro, 0x8000_0000 with PIPE_ADDSUB_SAT_EN.
REQ-039 8 back-to-back items with out_ready = 0 from the first result for 5 cycles -> in_ready = 0 and outputs stable while stalled; after release, 8 results in order, one per cycle.
REQ-040 3 items in flight, then rst_n = 0 for 1 cycle -> next cycle out_valid = 0, busy = 0, all outputs 0; no stale result afterwards.
